// File: rtl/a2d_pkg.sv
// Shared types and helpers for the A-line frame buffer.
//
// Contents:
//   wr_state_t - write-side FSM state (IDLE, FILL)
//   bank_t     - ping-pong bank identifier
//   offset_bin - two's-complement converter word -> offset-binary sample
//                (MSB inverted, keeps the top sample_w bits of the word)
package a2d_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } wr_state_t;

    typedef logic bank_t;

    // The result is returned in a 16-bit container; the caller truncates it
    // to its own sample width.
    function automatic logic [15:0] offset_bin(input logic [31:0] raw,
                                               input int unsigned adc_w,
                                               input int unsigned sample_w);
        logic [31:0] t;
        t = raw >> (adc_w - sample_w);
        t = t ^ (32'd1 << (sample_w - 1));
        t = t & ((32'd1 << sample_w) - 32'd1);
        return t[15:0];
    endfunction

endpackage

// File: rtl/a2d_dpram.sv
// Frame storage: two banks of DEPTH 32-bit words, addressed {bank, word}.
//
// Ports:
//   adclk  - clock, rising edge
//   rst_n  - synchronous active-low reset (clears the read register only)
//   we     - write enable;  waddr / wdata - write address and data
//   re     - read enable;   raddr         - read address
//   rdata  - registered read data, holds while re is low
module a2d_dpram #(
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH) + 1
) (
    input  logic          adclk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2*DEPTH];

    always_ff @(posedge adclk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge adclk) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/a2d_frame_buf.sv
// A-line frame buffer: on a trigger edge captures DEPTH*K converter samples
// (K = 32/SAMPLE_W per word, first sample in the LSBs) into one of two
// ping-pong banks, then exposes the oldest full bank to a slave read port.
//
// Ports:
//   adclk    - clock, rising edge
//   rst_n    - synchronous active-low reset
//   a2dc     - two's-complement converter sample, one per cycle
//   trig     - A-line trigger, rising edge starts a frame
//   cs_n, rd - slave select (active-low) and read strobe
//   addr     - word address within the ready bank
//   ovr_clr  - clears the sticky overrun flag
//   waitreq  - high while no bank is ready
//   a2do     - registered read data
//   bank_rdy - a complete frame is readable
//   overrun  - sticky: a trigger was dropped because both banks were full
//
// Build option: define A2D_TESTPAT_EN to replace converter samples with a
// ramp that starts at 0 on the trigger-edge sample.
module a2d_frame_buf
    import a2d_pkg::*;
#(
    parameter  int ADC_W    = 12,
    parameter  int SAMPLE_W = 8,
    parameter  int DEPTH    = 512,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              adclk,
    input  logic              rst_n,
    input  logic [ADC_W-1:0]  a2dc,
    input  logic              trig,
    input  logic              cs_n,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic              ovr_clr,
    output logic              waitreq,
    output logic [31:0]       a2do,
    output logic              bank_rdy,
    output logic              overrun
);

    localparam int K     = 32 / SAMPLE_W;
    localparam int KW    = $clog2(K);
    localparam int CNT_W = ADDR_W + KW;

    wr_state_t          state_q, state_d;
    logic               trig_q;
    bank_t              wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [1:0]         used_q, used_d;   // bank claimed by a fill, until released
    logic [1:0]         full_q, full_d;   // bank holds a complete frame
    logic [CNT_W-1:0]   cnt_q;            // {word index, slot within word}
    logic [31:0]        pack_q;
    logic               overrun_q;

    logic               trig_edge, start, drop, cap, last, word_done;
    logic               rd_acc, bank_release;
    logic [SAMPLE_W-1:0] sample_p0;
    logic [31:0]        word_p0;

    logic               wr_vld_p1, wr_last_p1;
    logic [ADDR_W:0]    wr_addr_p1;
    logic [31:0]        wr_data_p1;

    logic               done_vld_p2;
    bank_t              done_bank_p2;

    // ---- stage p0: trigger detect, sample conversion, packing ----
    assign trig_edge = trig & ~trig_q;
    // Only the bank at wr_ptr can be next; if it is still claimed the other
    // one is too (it is older), so both are occupied.
    assign start     = (state_q == IDLE) & trig_edge & ~used_q[wr_ptr_q];
    assign drop      = (state_q == IDLE) & trig_edge &  used_q[wr_ptr_q];
    assign cap       = start | (state_q == FILL);
    assign word_done = cap & (&cnt_q[KW-1:0]);
    assign last      = cap & (&cnt_q);

`ifdef A2D_TESTPAT_EN
    logic [SAMPLE_W-1:0] ramp_q;

    assign sample_p0 = start ? '0 : ramp_q;

    always_ff @(posedge adclk) begin
        if (cap)
            ramp_q <= sample_p0 + SAMPLE_W'(1);
    end
`else
    assign sample_p0 = SAMPLE_W'(offset_bin(32'(a2dc), ADC_W, SAMPLE_W));
`endif

    // New samples enter at the top, so after K shifts the first is in the LSBs.
    assign word_p0 = {sample_p0, pack_q[31:SAMPLE_W]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL:    if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- stage p1: word write into the bank ----
    // ---- stage p2: frame complete -> bank marked full ----
    assign bank_rdy     = full_q[rd_ptr_q];
    assign waitreq      = ~bank_rdy;
    assign overrun      = overrun_q;
    assign rd_acc       = ~cs_n & rd & ~waitreq;
    assign bank_release = rd_acc & (addr == ADDR_W'(DEPTH - 1));

    // A release and a fill-complete touch different banks, so both apply.
    always_comb begin
        used_d   = used_q;
        full_d   = full_q;
        rd_ptr_d = rd_ptr_q;
        if (bank_release) begin
            used_d[rd_ptr_q] = 1'b0;
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end
        if (start)
            used_d[wr_ptr_q] = 1'b1;
        if (done_vld_p2)
            full_d[done_bank_p2] = 1'b1;
    end

    always_ff @(posedge adclk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            trig_q      <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            used_q      <= '0;
            full_q      <= '0;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
            wr_vld_p1   <= 1'b0;
            wr_last_p1  <= 1'b0;
            done_vld_p2 <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_q      <= trig;
            rd_ptr_q    <= rd_ptr_d;
            used_q      <= used_d;
            full_q      <= full_d;
            if (cap)
                cnt_q <= cnt_q + CNT_W'(1);
            if (last)
                wr_ptr_q <= ~wr_ptr_q;
            if (drop)
                overrun_q <= 1'b1;
            else if (ovr_clr)
                overrun_q <= 1'b0;
            wr_vld_p1   <= word_done;
            wr_last_p1  <= last;
            done_vld_p2 <= wr_vld_p1 & wr_last_p1;
        end
    end

    always_ff @(posedge adclk) begin
        if (cap)
            pack_q <= word_p0;
        wr_data_p1   <= word_p0;
        wr_addr_p1   <= {wr_ptr_q, cnt_q[CNT_W-1:KW]};
        done_bank_p2 <= wr_addr_p1[ADDR_W];
    end

    a2d_dpram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .adclk (adclk),
        .rst_n (rst_n),
        .we    (wr_vld_p1),
        .waddr (wr_addr_p1),
        .wdata (wr_data_p1),
        .re    (rd_acc),
        .raddr ({rd_ptr_q, addr}),
        .rdata (a2do)
    );

endmodule
